riscv_mc_ctrl: RTL and testbench

Multi-cycle control unit for the kana-riscv core. A state machine sequences one instruction at a time through fetch, decode, execute, memory and writeback. Each cycle it drives the operand-select muxes (op1/op2), the ALU mode, the PC/IR/register-file write enables and the instruction/data memory request handshakes. It sits beside the datapath, reads only the latched instruction and the branch comparator result, and keeps a retired-instruction counter.

---
 rtl/riscv_mc_ctrl_pkg.sv | 28 ++
 rtl/riscv_mc_ctrl_decode.sv | 29 ++
 rtl/riscv_mc_ctrl.sv | 159 +++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared types for the kana-riscv multi-cycle controller: mux selects, FSM states,
// opcode classes and the RV32I major opcodes.
package riscv_mc_ctrl_pkg;

  typedef enum logic [1:0] {PC_4, PC_ALU, PC_ALUREG} pc_sel_t;
  typedef enum logic [1:0] {OP1_RS1, OP1_PC, OP1_ZERO} op1_sel_t;
  typedef enum logic       {OP2_RS2, OP2_IMM} op2_sel_t;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  typedef enum logic [3:0] {
    CL_OP, CL_OPIMM, CL_LUI, CL_AUIPC, CL_JAL, CL_JALR,
    CL_BRANCH, CL_LOAD, CL_STORE, CL_ILLEGAL
  } op_class_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/riscv_mc_ctrl_decode.sv
// Combinational opcode classifier: maps instr[6:0] to an op class plus a legality flag.
module riscv_mc_ctrl_decode
  import riscv_mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class,
  output logic       legal
);

  always_comb begin
    op_class = CL_ILLEGAL;
    unique case (opcode)
      OPC_OP:     op_class = CL_OP;
      OPC_OPIMM:  op_class = CL_OPIMM;
      OPC_LUI:    op_class = CL_LUI;
      OPC_AUIPC:  op_class = CL_AUIPC;
      OPC_JAL:    op_class = CL_JAL;
      OPC_JALR:   op_class = CL_JALR;
      OPC_BRANCH: op_class = CL_BRANCH;
      OPC_LOAD:   op_class = CL_LOAD;
      OPC_STORE:  op_class = CL_STORE;
      // SYSTEM is deliberately unsupported and traps like any unknown opcode
      default:    op_class = CL_ILLEGAL;
    endcase
  end

  assign legal = (op_class != CL_ILLEGAL);

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle control FSM for kana-riscv: sequences one instruction through
// fetch/decode/exec/mem/wb, drives datapath selects and counts retired instructions.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_FETCH  | imem request held until imem_ready, then IR load
//   S_DECODE | opcode class latched; illegal opcodes divert to S_TRAP
//   S_EXEC   | ALU result registered; branches resolve and retire here
//   S_MEM    | data request held until dmem_ready; stores retire here
//   S_WB     | register-file write and PC update, retire
//   S_TRAP   | everything idle, halted=1, left only by rst
module riscv_mc_ctrl
  import riscv_mc_ctrl_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGTH-1:0] instr,
  input  logic                   branch_taken,
  output logic                   imem_req,
  input  logic                   imem_ready,
  output logic                   dmem_req,
  output logic                   dmem_we,
  input  logic                   dmem_ready,
  output logic                   ir_we,
  output logic                   pc_we,
  output logic                   rf_we,
  output logic                   aluout_we,
  output pc_sel_t                pc_sel,
  output op1_sel_t               op1_sel,
  output op2_sel_t               op2_sel,
  output wb_sel_t                wb_sel,
  output logic                   alu_add,
  output logic                   halted,
  output logic [31:0]            instret
);

  state_t    state, state_next;
  op_class_t cls_q, cls_dec;
  logic      cls_legal;
  logic      retire;
  logic      halted_q;
  logic [31:0] instret_q;

  // Only the opcode field steers control; the rest of the word feeds the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[WORD_LENGTH-1:7];

  riscv_mc_ctrl_decode u_decode (
    .opcode   (instr[6:0]),
    .op_class (cls_dec),
    .legal    (cls_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      cls_q     <= CL_OP;
      halted_q  <= 1'b0;
      instret_q <= '0;
    end else begin
      state    <= state_next;
      halted_q <= (state_next == S_TRAP);
      if (state == S_DECODE) cls_q <= cls_dec;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    rf_we      = 1'b0;
    aluout_we  = 1'b0;
    pc_sel     = PC_4;
    op1_sel    = OP1_RS1;
    op2_sel    = OP2_RS2;
    wb_sel     = WB_ALU;
    alu_add    = 1'b0;
    retire     = 1'b0;
    // rst gates every output in the same cycle so requests drop immediately
    if (!rst) begin
      unique case (state)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we      = 1'b1;
            state_next = S_DECODE;
          end
        end
        S_DECODE: state_next = cls_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          aluout_we  = 1'b1;
          state_next = S_WB;
          unique case (cls_q)
            CL_OP: ;
            CL_OPIMM: op2_sel = OP2_IMM;
            CL_LUI: begin
              op1_sel = OP1_ZERO; op2_sel = OP2_IMM; alu_add = 1'b1;
            end
            CL_AUIPC, CL_JAL: begin
              op1_sel = OP1_PC; op2_sel = OP2_IMM; alu_add = 1'b1;
            end
            CL_JALR: begin
              op2_sel = OP2_IMM; alu_add = 1'b1;
            end
            CL_LOAD, CL_STORE: begin
              op2_sel = OP2_IMM; alu_add = 1'b1; state_next = S_MEM;
            end
            CL_BRANCH: begin
              op1_sel    = OP1_PC;
              op2_sel    = OP2_IMM;
              alu_add    = 1'b1;
              pc_we      = 1'b1;
              pc_sel     = branch_taken ? PC_ALU : PC_4;
              retire     = 1'b1;
              state_next = S_FETCH;
            end
            default: state_next = S_TRAP;
          endcase
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (cls_q == CL_STORE);
          if (dmem_ready) begin
            if (cls_q == CL_STORE) begin
              pc_we      = 1'b1;
              retire     = 1'b1;
              state_next = S_FETCH;
            end else begin
              state_next = S_WB;
            end
          end
        end
        S_WB: begin
          rf_we      = 1'b1;
          pc_we      = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
          if (cls_q == CL_LOAD) wb_sel = WB_MEM;
          if (cls_q == CL_JAL || cls_q == CL_JALR) begin
            wb_sel = WB_PC4;
            pc_sel = PC_ALUREG;
          end
        end
        S_TRAP: state_next = S_TRAP;
        default: state_next = S_FETCH;
      endcase
    end
  end

  assign halted  = halted_q & ~rst;
  assign instret = rst ? 32'd0 : instret_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Directed bench for riscv_mc_ctrl: walks ADDI, LW with waits, SW, BEQ both ways,
// JAL, an illegal opcode trap and a reset during MEM, against hand-derived values.
module tb_riscv_mc_ctrl;
  import riscv_mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        branch_taken;
  logic        imem_req, imem_ready;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        ir_we, pc_we, rf_we, aluout_we;
  pc_sel_t     pc_sel;
  op1_sel_t    op1_sel;
  op2_sel_t    op2_sel;
  wb_sel_t     wb_sel;
  logic        alu_add, halted;
  logic [31:0] instret;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.WORD_LENGTH(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .aluout_we(aluout_we),
    .pc_sel(pc_sel), .op1_sel(op1_sel), .op2_sel(op2_sel), .wb_sel(wb_sel),
    .alu_add(alu_add), .halted(halted), .instret(instret)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [6:0] enables();
    return {ir_we, pc_we, rf_we, aluout_we, imem_req, dmem_req, dmem_we};
  endfunction

  initial begin
    rst = 1'b1; instr = 32'h0; branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b1;

    // reset: everything idle even with ready inputs high
    repeat (2) @(negedge clk);
    #1;
    check("rst_enables", {25'd0, enables()}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_instret", instret, 32'd0);

    // ADDI x1,x0,5
    @(negedge clk); rst = 1'b0; instr = 32'h00500093; #1;
    check("addi_fetch_req", {31'd0, imem_req}, 32'd1);
    check("addi_fetch_irwe", {31'd0, ir_we}, 32'd1);
    step();
    check("addi_dec_enables", {25'd0, enables()}, 32'd0);
    step();
    check("addi_ex_op1", op1_sel, OP1_RS1);
    check("addi_ex_op2", op2_sel, OP2_IMM);
    check("addi_ex_add", {31'd0, alu_add}, 32'd0);
    check("addi_ex_aluwe", {31'd0, aluout_we}, 32'd1);
    step();
    check("addi_wb_rfwe", {31'd0, rf_we}, 32'd1);
    check("addi_wb_sel", wb_sel, WB_ALU);
    check("addi_wb_pcwe", {31'd0, pc_we}, 32'd1);
    check("addi_wb_pcsel", pc_sel, PC_4);
    check("addi_wb_instret", instret, 32'd0);
    step();
    check("addi_back_fetch", {31'd0, imem_req}, 32'd1);
    check("addi_instret", instret, 32'd1);

    // LW x2,0(x1): one imem wait cycle, then three dmem wait cycles
    imem_ready = 1'b0; instr = 32'h0000A103; #1;
    check("lw_fetch_wait_irwe", {31'd0, ir_we}, 32'd0);
    check("lw_fetch_wait_req", {31'd0, imem_req}, 32'd1);
    step(); imem_ready = 1'b1; #1;
    check("lw_fetch_irwe", {31'd0, ir_we}, 32'd1);
    step();
    step();
    check("lw_ex_op2", op2_sel, OP2_IMM);
    check("lw_ex_add", {31'd0, alu_add}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(); dmem_ready = (i == 3); #1;
      check("lw_mem_req", {31'd0, dmem_req}, 32'd1);
      check("lw_mem_we", {31'd0, dmem_we}, 32'd0);
      check("lw_mem_pcwe", {31'd0, pc_we}, 32'd0);
    end
    step();
    check("lw_wb_sel", wb_sel, WB_MEM);
    check("lw_wb_rfwe", {31'd0, rf_we}, 32'd1);
    step();
    check("lw_instret", instret, 32'd2);

    // SW x2,0(x1)
    instr = 32'h0020A023;
    step(); step();
    check("sw_ex_op2", op2_sel, OP2_IMM);
    step();
    check("sw_mem_we", {31'd0, dmem_we}, 32'd1);
    check("sw_mem_pcwe", {31'd0, pc_we}, 32'd1);
    check("sw_mem_pcsel", pc_sel, PC_4);
    check("sw_mem_rfwe", {31'd0, rf_we}, 32'd0);
    step();
    check("sw_back_fetch", {31'd0, imem_req}, 32'd1);
    check("sw_instret", instret, 32'd3);

    // BEQ taken then not taken
    instr = 32'h00208463;
    for (int t = 1; t >= 0; t--) begin
      branch_taken = t[0];
      step(); step();
      check("beq_ex_op1", op1_sel, OP1_PC);
      check("beq_ex_pcwe", {31'd0, pc_we}, 32'd1);
      check("beq_ex_pcsel", pc_sel, t[0] ? PC_ALU : PC_4);
      step();
      check("beq_back_fetch", {31'd0, imem_req}, 32'd1);
      check("beq_instret", instret, (t[0] ? 32'd4 : 32'd5));
    end
    branch_taken = 1'b0;

    // JAL x1,+8
    instr = 32'h008000EF;
    step(); step();
    check("jal_ex_op1", op1_sel, OP1_PC);
    check("jal_ex_op2", op2_sel, OP2_IMM);
    check("jal_ex_add", {31'd0, alu_add}, 32'd1);
    step();
    check("jal_wb_sel", wb_sel, WB_PC4);
    check("jal_wb_pcsel", pc_sel, PC_ALUREG);
    check("jal_wb_rfwe", {31'd0, rf_we}, 32'd1);
    check("jal_wb_pcwe", {31'd0, pc_we}, 32'd1);
    step();
    check("jal_instret", instret, 32'd6);

    // illegal opcode traps and stays put
    instr = 32'h0000007F;
    step();
    check("trap_dec_halted", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("trap_halted", {31'd0, halted}, 32'd1);
      check("trap_enables", {25'd0, enables()}, 32'd0);
      check("trap_instret", instret, 32'd6);
    end

    // reset out of trap, then reset in the middle of a load's MEM wait
    rst = 1'b1; #1;
    check("trap_rst_halted", {31'd0, halted}, 32'd0);
    step(); rst = 1'b0; instr = 32'h0000A103; dmem_ready = 1'b0; #1;
    check("post_trap_fetch", {31'd0, imem_req}, 32'd1);
    step(); step(); step();
    check("rstmem_req_before", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1; #1;
    check("rstmem_req_same", {31'd0, dmem_req}, 32'd0);
    step();
    check("rstmem_req_next", {31'd0, dmem_req}, 32'd0);
    check("rstmem_instret", instret, 32'd0);
    rst = 1'b0; #1;
    check("rstmem_fetch_req", {31'd0, imem_req}, 32'd1);
    check("rstmem_fetch_dreq", {31'd0, dmem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
